mastermind_feedback: RTL
========================

// Module: mastermind_feedback
// PURPOSE
//  Downstream scoring stage of the Mastermind core. On a start pulse it latches the
//  submitted guess and the secret answer, both packed as NUM_PEGS colour codes.
//  It scores the guess over several cycles and returns Mastermind feedback:
//  exact hits (right colour, right slot) and partial hits (right colour, wrong slot).
//  The core's check state drives start. The counts feed the LED/VGA result display.
// PARAMETERS
//  NUM_PEGS   4  pegs per guess; peg i = bits [i*COLOR_W +: COLOR_W]
//  COLOR_W    3  bits per colour code
//  NUM_COLORS 6  legal colour codes are 1..NUM_COLORS; code 0 = empty slot
// PORTS
//  sys_clk      in   1                 system clock (100 MHz)
//  Reset        in   1                 asynchronous, active-high reset
//  start        in   1                 1-cycle request to score guess vs answer
//  guess        in   NUM_PEGS*COLOR_W  packed guess; sampled only on accepted start
//  answer       in   NUM_PEGS*COLOR_W  packed secret; sampled only on accepted start
//  busy         out  1                 high from the accept edge until done deasserts
//  done         out  1                 1-cycle pulse; result outputs valid from here on
//  exact_cnt    out  $clog2(NUM_PEGS+1)  number of exact hits
//  partial_cnt  out  $clog2(NUM_PEGS+1)  number of partial hits
//  win          out  1                 exact_cnt == NUM_PEGS
//  invalid      out  1                 guess or answer holds a code of 0 or > NUM_COLORS
// BEHAVIOUR
//  - Reset, at any time including mid-scoring:
//    - state=IDLE; all outputs 0; histograms and counters cleared.
//  - FSM states: IDLE, EXACT, COLOR, DONE.
//  - IDLE: start=1 is accepted at edge E0.
//    - Latch guess and answer; clear both counts and both histograms.
//    - If any peg of guess or answer is illegal: set invalid=1, counts=0, go to DONE.
//    - Otherwise: set invalid=0, idx=0, go to EXACT.
//  - EXACT: one peg per edge, idx 0..NUM_PEGS-1 (edges E1..E4 for defaults).
//    - If g[idx]==a[idx]: exact_cnt++.
//    - Else: hist_g[g[idx]]++ and hist_a[a[idx]]++.
//    - After the last peg: c=1, go to COLOR.
//  - COLOR: one colour per edge, c 1..NUM_COLORS (edges E5..E10).
//    - partial_cnt += min(hist_g[c], hist_a[c]).
//    - After the last colour: go to DONE.
//  - DONE: done=1 for exactly one cycle; next edge goes to IDLE.
//  - Latency: valid guess -> done high in the cycle after edge E(NUM_PEGS+NUM_COLORS), i.e. E10.
//    Invalid input -> done high in the cycle after E0.
//  - busy = (state != IDLE).
//  - start while busy is ignored; no queuing.
//  - start sampled in DONE is also ignored.
//  - exact_cnt, partial_cnt, win and invalid are registered.
//    - Values update during scoring.
//    - Values are guaranteed only from done onward.
//    - Values are held until the next accepted start.
//  - win is set on the EXACT->COLOR transition when exact_cnt==NUM_PEGS.
//  - Width rules:
//    - histogram entries are $clog2(NUM_PEGS+1) bits; they cannot overflow.
//    - exact_cnt + partial_cnt <= NUM_PEGS always.
//  - guess/answer changing after E0 have no effect on the result.
// STRUCTURE
//  - Shared package mastermind_pkg:
//    - COLOR_W, NUM_PEGS, NUM_COLORS.
//    - Colour code constants 3'b001..3'b110, matching the one-hot switch decode in the top.
//    - FSM state encoding.
//  - Single flat module, no sub-module:
//    - histograms are two register arrays indexed by colour;
//    - min() is a local compare.
//  - Indices: idx is $clog2(NUM_PEGS) bits; c is $clog2(NUM_COLORS+1) bits.
// TESTING
//  1. answer=12'h29C, guess=12'h29C, start at E0
//     -> done after E10; exact=4, partial=0, win=1, invalid=0.
//  2. answer=12'h249 (all colour 1), guess=12'h292
//     -> exact=1, partial=0, win=0.
//  3. answer=12'h29C, guess=12'h8D1 (reversed)
//     -> exact=0, partial=4.
//  4. Duplicates: answer=12'h252, guess=12'h48B
//     -> exact=0, partial=3 (colour1 min(1,2) + colour2 min(2,2)).
//  5. guess=12'h290 (peg0 = 0)
//     -> done in the cycle after E0; invalid=1, exact=partial=0, busy low after E1.
//  6. Reset asserted at E5 of a scoring run
//     -> all outputs 0 immediately, IDLE.
//     Then start pulse at E3 of a second run -> ignored; result matches the first request only.

Source files
------------

// File: rtl/mastermind_pkg.sv
// Shared definitions for the Mastermind core: sizing constants, colour codes,
// scoring FSM encoding and the colour-code decode used for legality checks.
package mastermind_pkg;

   localparam int COLOR_W    = 3;
   localparam int NUM_PEGS   = 4;
   localparam int NUM_COLORS = 6;

   localparam int CODE_W = NUM_PEGS * COLOR_W;
   localparam int CNT_W  = $clog2(NUM_PEGS + 1);
   localparam int IDX_W  = $clog2(NUM_PEGS);
   localparam int CLR_W  = $clog2(NUM_COLORS + 1);

   // Colour codes; 0 marks an empty slot, codes above the last colour are unused.
   localparam logic [COLOR_W-1:0] COLOR_EMPTY  = 3'b000;
   localparam logic [COLOR_W-1:0] COLOR_RED    = 3'b001;
   localparam logic [COLOR_W-1:0] COLOR_GREEN  = 3'b010;
   localparam logic [COLOR_W-1:0] COLOR_BLUE   = 3'b011;
   localparam logic [COLOR_W-1:0] COLOR_YELLOW = 3'b100;
   localparam logic [COLOR_W-1:0] COLOR_ORANGE = 3'b101;
   localparam logic [COLOR_W-1:0] COLOR_PURPLE = 3'b110;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_EXACT = 2'd1,
      ST_COLOR = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   // One-hot decode of a colour code, same mapping as the switch decode;
   // an all-zero result means the code is empty or out of range.
   function automatic logic [NUM_COLORS-1:0] color_onehot(input logic [COLOR_W-1:0] code);
      logic [NUM_COLORS-1:0] oh;
      oh = '0;
      case (code)
         COLOR_RED:    oh[0] = 1'b1;
         COLOR_GREEN:  oh[1] = 1'b1;
         COLOR_BLUE:   oh[2] = 1'b1;
         COLOR_YELLOW: oh[3] = 1'b1;
         COLOR_ORANGE: oh[4] = 1'b1;
         COLOR_PURPLE: oh[5] = 1'b1;
         default:      oh    = '0;
      endcase
      return oh;
   endfunction

endpackage

// File: rtl/mastermind_feedback.sv
// Mastermind scoring stage: latches guess/answer on start, counts exact hits
// one peg per cycle while building per-colour histograms of the unmatched
// pegs, then sums min(hist_g, hist_a) one colour per cycle for partial hits.
module mastermind_feedback
   import mastermind_pkg::*;
(
   input  logic              sys_clk,
   input  logic              Reset,
   input  logic              start,
   input  logic [CODE_W-1:0] guess,
   input  logic [CODE_W-1:0] answer,
   output logic              busy,
   output logic              done,
   output logic [CNT_W-1:0]  exact_cnt,
   output logic [CNT_W-1:0]  partial_cnt,
   output logic              win,
   output logic              invalid
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PEGS - 1);
   localparam logic [CLR_W-1:0] LAST_CLR = CLR_W'(NUM_COLORS);
   localparam logic [CNT_W-1:0] ALL_HIT  = CNT_W'(NUM_PEGS);

   state_t              state_reg, state_next;
   logic [CODE_W-1:0]   guess_reg, answer_reg;
   logic [IDX_W-1:0]    idx_reg;
   logic [CLR_W-1:0]    clr_reg;
   logic [CNT_W-1:0]    hist_g_reg [0:NUM_COLORS];
   logic [CNT_W-1:0]    hist_a_reg [0:NUM_COLORS];

   logic [NUM_PEGS-1:0] peg_bad;
   logic                any_bad;
   logic [COLOR_W-1:0]  g_peg, a_peg;
   logic                peg_hit;
   logic [CNT_W-1:0]    exact_sum;
   logic [CNT_W-1:0]    hg_cur, ha_cur, min_hist;

   // A peg is bad if either the guess or the answer code decodes to no colour.
   generate
      for (genvar gi = 0; gi < NUM_PEGS; gi++) begin : g_legal
         assign peg_bad[gi] = ~(|color_onehot(guess[gi*COLOR_W +: COLOR_W]))
                            | ~(|color_onehot(answer[gi*COLOR_W +: COLOR_W]));
      end
   endgenerate

   assign any_bad   = |peg_bad;
   assign g_peg     = guess_reg[idx_reg*COLOR_W +: COLOR_W];
   assign a_peg     = answer_reg[idx_reg*COLOR_W +: COLOR_W];
   assign peg_hit   = (g_peg == a_peg);
   assign exact_sum = exact_cnt + CNT_W'(peg_hit);
   assign hg_cur    = hist_g_reg[clr_reg];
   assign ha_cur    = hist_a_reg[clr_reg];
   assign min_hist  = (hg_cur < ha_cur) ? hg_cur : ha_cur;

   assign busy = (state_reg != ST_IDLE);
   assign done = (state_reg == ST_DONE);

   // State register.
   always_ff @(posedge sys_clk or posedge Reset) begin
      if (Reset) state_reg <= ST_IDLE;
      else       state_reg <= state_next;
   end

   // Next-state logic: illegal codes skip straight to DONE.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE:  if (start) state_next = any_bad ? ST_DONE : ST_EXACT;
         ST_EXACT: if (idx_reg == LAST_IDX) state_next = ST_COLOR;
         ST_COLOR: if (clr_reg == LAST_CLR) state_next = ST_DONE;
         ST_DONE:  state_next = ST_IDLE;
         default:  state_next = ST_IDLE;
      endcase
   end

   // Scoring datapath: operand capture, exact/histogram pass, colour pass.
   always_ff @(posedge sys_clk or posedge Reset) begin
      if (Reset) begin
         guess_reg   <= '0;
         answer_reg  <= '0;
         idx_reg     <= '0;
         clr_reg     <= '0;
         exact_cnt   <= '0;
         partial_cnt <= '0;
         win         <= 1'b0;
         invalid     <= 1'b0;
         for (int i = 0; i <= NUM_COLORS; i++) begin
            hist_g_reg[i] <= '0;
            hist_a_reg[i] <= '0;
         end
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (start) begin
                  guess_reg   <= guess;
                  answer_reg  <= answer;
                  idx_reg     <= '0;
                  clr_reg     <= '0;
                  exact_cnt   <= '0;
                  partial_cnt <= '0;
                  win         <= 1'b0;
                  invalid     <= any_bad;
                  for (int i = 0; i <= NUM_COLORS; i++) begin
                     hist_g_reg[i] <= '0;
                     hist_a_reg[i] <= '0;
                  end
               end
            end
            ST_EXACT: begin
               // Only unmatched pegs enter the histograms, so exact hits
               // are never double-counted as partial hits.
               if (peg_hit) begin
                  exact_cnt <= exact_sum;
               end else begin
                  hist_g_reg[g_peg] <= hist_g_reg[g_peg] + CNT_W'(1);
                  hist_a_reg[a_peg] <= hist_a_reg[a_peg] + CNT_W'(1);
               end
               idx_reg <= idx_reg + IDX_W'(1);
               if (idx_reg == LAST_IDX) begin
                  win     <= (exact_sum == ALL_HIT);
                  clr_reg <= CLR_W'(1);
               end
            end
            ST_COLOR: begin
               partial_cnt <= partial_cnt + min_hist;
               clr_reg     <= clr_reg + CLR_W'(1);
            end
            default: ;
         endcase
      end
   end

endmodule
